// File: rtl/ifu_fetch_ctrl_pkg.sv
// rtl/ifu_fetch_ctrl_pkg.sv - shared fetch state encodings and reset PC
package ifu_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH_ST_IDLE = 2'd0,
    FETCH_ST_REQ  = 2'd1,
    FETCH_ST_WAIT = 2'd2,
    FETCH_ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// rtl/ifu_fetch_ctrl_if.sv - SRAM-like instruction bus between fetch engine and memory
interface ifu_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata_1;
  logic [31:0] inst_rdata_2;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata_1, inst_rdata_2
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata_1, inst_rdata_2
  );
endinterface

// File: rtl/ifu_fetch_ctrl_hold_buf.sv
// rtl/ifu_fetch_ctrl_hold_buf.sv - one-entry {pc, inst1, inst2} buffer for stalled deliveries
module ifu_fetch_ctrl_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_1_in,
  input  logic [31:0] inst_2_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst_1,
  output logic [31:0] inst_2
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      pc     <= '0;
      inst_1 <= '0;
      inst_2 <= '0;
    end else if (capture) begin
      valid  <= 1'b1;
      pc     <= pc_in;
      inst_1 <= inst_1_in;
      inst_2 <= inst_2_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - fetch PC owner and single-outstanding instruction bus requester
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             next_pc,
  input  logic                    flush_req,
  input  logic                    exception_pc_ena,
  input  logic                    stall,
  ifu_fetch_ctrl_if.master        bus,
  output logic [31:0]             pc,
  output logic                    inst_rdata_1_ok,
  output logic                    inst_rdata_2_ok,
  output logic [31:0]             fetch_pc,
  output logic [31:0]             fetch_inst_1,
  output logic [31:0]             fetch_inst_2,
  output logic                    fetch_adel
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_q;
  logic         cancel_q;

  logic redirect, misaligned;
  logic pc_load, cancel_set, cancel_clr;
  logic hold_capture, hold_clear, hold_valid;
  logic deliver_bus, deliver_hold, deliver_adel;
  logic [31:0] hold_pc, hold_inst_1, hold_inst_2;

  assign redirect   = flush_req | exception_pc_ena;
  assign misaligned = |pc_q[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH_ST_IDLE;
      pc_q     <= RESET_PC;
      cancel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pc_load) pc_q <= next_pc;
      if (cancel_set) cancel_q <= 1'b1;
      else if (cancel_clr) cancel_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_load      = 1'b0;
    cancel_set   = 1'b0;
    cancel_clr   = 1'b0;
    hold_capture = 1'b0;
    hold_clear   = 1'b0;
    deliver_bus  = 1'b0;
    deliver_hold = 1'b0;
    deliver_adel = 1'b0;
    bus.inst_req = 1'b0;
    case (state)
      FETCH_ST_IDLE: begin
        state_nxt = FETCH_ST_REQ;
        pc_load   = redirect;
      end
      FETCH_ST_REQ: begin
        if (misaligned) begin
          // Misaligned PC never reaches the bus; it retires as an ADEL slot.
          if (redirect) begin
            pc_load = 1'b1;
          end else if (!stall) begin
            deliver_adel = 1'b1;
            pc_load      = 1'b1;
          end
        end else begin
          bus.inst_req = 1'b1;
          if (bus.inst_addr_ok) begin
            state_nxt = FETCH_ST_WAIT;
            if (redirect) begin
              pc_load    = 1'b1;
              cancel_set = 1'b1;
            end
          end else if (redirect) begin
            pc_load = 1'b1;
          end
        end
      end
      FETCH_ST_WAIT: begin
        if (bus.inst_data_ok) begin
          state_nxt = FETCH_ST_REQ;
          if (cancel_q) begin
            cancel_clr = 1'b1;
            pc_load    = redirect;
          end else if (redirect) begin
            pc_load = 1'b1;
          end else if (!stall) begin
            deliver_bus = 1'b1;
            pc_load     = 1'b1;
          end else begin
            hold_capture = 1'b1;
            state_nxt    = FETCH_ST_HOLD;
          end
        end else if (redirect) begin
          cancel_set = 1'b1;
          pc_load    = 1'b1;
        end
      end
      FETCH_ST_HOLD: begin
        if (redirect) begin
          hold_clear = 1'b1;
          pc_load    = 1'b1;
          state_nxt  = FETCH_ST_REQ;
        end else if (!stall && hold_valid) begin
          deliver_hold = 1'b1;
          hold_clear   = 1'b1;
          pc_load      = 1'b1;
          state_nxt    = FETCH_ST_REQ;
        end
      end
      default: state_nxt = FETCH_ST_IDLE;
    endcase
  end

  ifu_fetch_ctrl_hold_buf u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .capture   (hold_capture),
    .clear     (hold_clear),
    .pc_in     (pc_q),
    .inst_1_in (bus.inst_rdata_1),
    .inst_2_in (bus.inst_rdata_2),
    .valid     (hold_valid),
    .pc        (hold_pc),
    .inst_1    (hold_inst_1),
    .inst_2    (hold_inst_2)
  );

  assign bus.inst_addr   = pc_q;
  assign pc              = pc_q;
  assign inst_rdata_1_ok = deliver_bus | deliver_hold | deliver_adel;
  assign inst_rdata_2_ok = (deliver_bus & ~pc_q[2]) | (deliver_hold & ~hold_pc[2]);
  assign fetch_adel      = deliver_adel;
  assign fetch_pc        = deliver_hold ? hold_pc :
                           (deliver_bus | deliver_adel) ? pc_q : 32'd0;
  assign fetch_inst_1    = deliver_hold ? hold_inst_1 :
                           deliver_bus ? bus.inst_rdata_1 : 32'd0;
  assign fetch_inst_2    = deliver_hold ? hold_inst_2 :
                           deliver_bus ? bus.inst_rdata_2 : 32'd0;

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Instruction-fetch request engine at the front of the IFU. It owns the architectural fetch PC register and issues requests on the SRAM-like instruction bus. It returns one or two fetched instructions per transaction, signalled by inst_rdata_1_ok / inst_rdata_2_ok, which npc consumes to form next_pc. It also cancels in-flight fetches on a branch redirect (flush_req) or an exception redirect.

Parameters:
RESET_PC, 32'hbfc00000, fetch PC loaded on reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
next_pc  in  32  PC selected by npc; sampled whenever pc updates
flush_req  in  1  branch/jump redirect from npc
exception_pc_ena  in  1  exception redirect; same effect as flush_req
stall  in  1  fetch buffer cannot accept a delivery this cycle
inst_req  out  1  bus request
inst_addr  out  32  bus address, equal to pc
inst_addr_ok  in  1  address accepted
inst_data_ok  in  1  read data returned
inst_rdata_1  in  32  word at inst_addr
inst_rdata_2  in  32  word at inst_addr+4; meaningful only when inst_addr[2]==0
pc  out  32  current fetch PC, to npc
inst_rdata_1_ok  out  1  slot 1 delivered this cycle
inst_rdata_2_ok  out  1  slot 2 delivered this cycle
fetch_pc  out  32  PC of slot 1
fetch_inst_1  out  32  slot 1 instruction
fetch_inst_2  out  32  slot 2 instruction
fetch_adel  out  1  slot 1 carries an instruction address-error exception

Behaviour:
- Redirect means flush_req | exception_pc_ena.
- Reset: pc=RESET_PC; state=IDLE; cancel=0; hold buffer invalid; inst_req=0; all *_ok, fetch_adel=0; fetch_inst_*=0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: moves to REQ on the next cycle. Redirect in IDLE: pc<=next_pc.
- REQ: inst_req=1, inst_addr=pc.
  - If pc[1:0]!=0: inst_req=0. When !stall, deliver slot 1 only with fetch_adel=1, fetch_inst_1=0, pc<=next_pc, stay REQ.
  - If addr_ok and no redirect: go to WAIT.
  - Redirect without addr_ok: pc<=next_pc, stay REQ (address may change before acceptance).
  - Redirect with addr_ok: pc<=next_pc, cancel<=1, go to WAIT.
- WAIT: inst_req=0.
  - data_ok with cancel=1: drop the data, cancel<=0, go to REQ.
  - data_ok with redirect: drop the data, pc<=next_pc, go to REQ.
  - data_ok, !stall: deliver combinationally in the same cycle. inst_rdata_1_ok=1; inst_rdata_2_ok=~pc[2]; fetch_pc=pc; fetch_inst_1/2 = bus data. pc<=next_pc; go to REQ.
  - data_ok, stall: capture rdata_1, rdata_2 and pc into the hold buffer; go to HOLD; pc unchanged.
  - Redirect without data_ok: cancel<=1, pc<=next_pc.
- HOLD: when !stall, deliver from the buffer (same ok rules, using the buffered pc[2]); pc<=next_pc; go to REQ. Redirect: discard the buffer, pc<=next_pc, go to REQ.
- Outstanding transactions never exceed one. inst_rdata_*_ok are never asserted in a cycle with redirect.
- inst_rdata_2_ok implies inst_rdata_1_ok.
- Both *_ok are single-cycle pulses per delivery.
- Reset asserted mid-transaction returns the block to the reset state. The bus slave is reset concurrently, so no stale data_ok arrives.

Decomposition:
- Shared ifu package/defines: FETCH_ST_IDLE/REQ/WAIT/HOLD encodings, RESET_PC default.
- Optional sub-module fetch_hold_buf (one-entry {pc, inst1, inst2} register with valid); otherwise flat.

Test Plan:
- Reset then pc=32'hbfc00000: after 1 IDLE cycle, inst_req=1, inst_addr=32'hbfc00000. addr_ok, then data_ok with next_pc=32'hbfc00008 -> ok1=ok2=1, pc becomes 32'hbfc00008.
- pc=32'hbfc00004 fetch -> ok1=1, ok2=0, fetch_pc=32'hbfc00004.
- Redirect one cycle after addr_ok, next_pc=32'h80000100 -> following data_ok produces no ok pulses; next request has inst_addr=32'h80000100.
- stall=1 for 3 cycles across data_ok -> no ok pulses while stalled. Buffered words are delivered in the first !stall cycle, unchanged.
- next_pc=32'h80000102 taken -> no inst_req; ok1=1, fetch_adel=1, fetch_pc=32'h80000102.
- Redirect in the same cycle as data_ok -> data dropped; pc=next_pc next cycle; state REQ.
